alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//  Parametrised, sequential successor to the 32-bit combinational ALU: WIDTH-bit ops computed CHUNK bits per cycle.
//  Carry and zero are held in registers between chunks. Valid/ready handshakes on input and output.
//  Adds XOR, SLTU and NOR; corrects SLT (sign of x-y xor overflow); cout is a real carry-out, no longer a copy of overflow.
//  Sits between operand source and writeback in the datapath.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of CHUNK
//  CHUNK  8   bits processed per cycle; NCHUNK = WIDTH/CHUNK (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/opcode valid
//  in_ready   out  1      block can accept an operation
//  x, y       in   WIDTH  operands (two's complement for signed ops)
//  opcode     in   3      000 ADD, 001 OR, 010 AND, 011 SUB, 100 SLT, 101 XOR, 110 SLTU, 111 NOR
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  f          out  WIDTH  result
//  overflow   out  1      signed overflow (ADD/SUB only, else 0)
//  cout       out  1      carry out of MSB (ADD: x+y; SUB: x+~y+1, 1 = no borrow; else 0)
//  zero       out  1      f == 0
// BEHAVIOUR
//  - Reset (async): state=IDLE; out_valid=0; f=0; overflow=0; cout=0; zero=0; chunk counter=0; carry reg=0.
//    in_ready=1 while in reset. Reset mid-operation aborts; no result is ever delivered.
//  - FSM IDLE -> BUSY on in_valid&&in_ready; x, y, opcode captured.
//    Carry reg loads 1 for SUB/SLT/SLTU, else 0. y is inverted internally for SUB/SLT/SLTU.
//  - BUSY: per cycle, chunk k = cnt*CHUNK +: CHUNK is computed and written into the f register.
//    The carry reg is updated and the zero accumulator is ANDed with (chunk==0).
//    When cnt==NCHUNK-1: BUSY -> DONE, out_valid=1 on that same edge.
//  - Latency: result visible NCHUNK cycles after the accepting edge.
//  - DONE: f/flags stable while out_valid=1 and out_ready=0.
//    On out_valid&&out_ready: DONE -> IDLE, or DONE -> BUSY if in_valid in the same cycle (back-to-back).
//  - in_ready = (state==IDLE) || (state==DONE && out_ready); combinational, no input-to-output path except out_ready.
//  - Flags are finalised on the last chunk from c_in_msb (carry into bit WIDTH-1) and c_out:
//    ADD/SUB: overflow = c_in_msb^c_out; cout = c_out.
//    SLT:  f = {0, sum_msb^(c_in_msb^c_out)}, overflow=cout=0.
//    SLTU: f = {0, ~c_out}, overflow=cout=0.
//    Logic ops: overflow=cout=0.
//  - zero is computed on the final f: SLT/SLTU take zero from the 1-bit result, not from the chunk accumulator.
//  - Arithmetic is modulo 2^WIDTH; wrap-around is silent apart from the flags.
//  - Unused opcodes: none; all 8 are defined.
//  - in_valid while BUSY is ignored (in_ready=0); inputs may change freely after acceptance.
// STRUCTURE
//  - alu_pkg: opcode localparams (OP_ADD..OP_NOR), state encoding (ST_IDLE, ST_BUSY, ST_DONE), is_sub(op) function.
//  - Sub-module alu_chunk: combinational CHUNK-bit slice.
//    Inputs a, b (b pre-inverted), cin, op. Outputs res, cout, c_msb_in (carry into top bit of slice).
//  - Top: FSM, counter of width $clog2(NCHUNK)+1, operand/result/carry/zero registers, flag logic.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//  1. ADD 0x7FFFFFFF+0x00000001 -> f=0x80000000, overflow=1, cout=0, zero=0; out_valid exactly 4 cycles after accept.
//  2. SUB 5-5 -> f=0, zero=1, cout=1, overflow=0; SUB 0-1 -> f=0xFFFFFFFF, cout=0.
//  3. SLT 0x80000000,0x00000001 -> f=1; SLTU same operands -> f=0, zero=1; SLT 0x7FFFFFFF,0x80000000 -> f=0.
//  4. XOR 0xF0F0F0F0^0xFF00FF00 -> 0x0FF00FF0; NOR 0,0 -> 0xFFFFFFFF; OR/AND match 32-bit reference model.
//  5. Hold out_ready=0 for 3 cycles after out_valid -> f/flags stable, in_ready=0.
//     Raise out_ready with in_valid -> next op accepted the same edge, no idle bubble.
//  6. Assert rst in 2nd BUSY cycle -> out_valid stays 0, outputs cleared asynchronously, in_ready=1.
//     Also random regression vs golden model for CHUNK in {1,4,32}.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode helpers for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_NOR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ops that run the adder as x + ~y + 1
  function automatic logic is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
  endfunction

endpackage

// File: rtl/alu_chunk.sv
// Combinational CHUNK-bit ALU slice; b arrives already inverted for subtract-type ops.
module alu_chunk
  import alu_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [CHUNK-1:0] res,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] sum;

  assign sum      = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign cout     = sum[CHUNK];
  // carry into the slice's top bit recovered from the sum bit
  assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

  always_comb begin
    res = sum[CHUNK-1:0];
    case (op)
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      default: res = sum[CHUNK-1:0];
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Sequential ALU: WIDTH-bit ops computed CHUNK bits per cycle with valid/ready on both sides.
//   state   | meaning
//   ST_IDLE | waiting for an operation, in_ready=1
//   ST_BUSY | one chunk per cycle, carry and zero held in registers
//   ST_DONE | result held on f/flags until out_ready
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             overflow,
  output logic             cout,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  state_t state, state_nxt;

  logic [WIDTH-1:0] x_r, y_r, f_r;
  logic [2:0]       op_r;
  logic             carry_r, zero_acc;
  logic [CW-1:0]    cnt;
  logic             ov_r, co_r, zero_r;

  logic             accept, last, chunk_zero, lt;
  logic [31:0]      sh;
  logic [CHUNK-1:0] a_ch, b_ch, res;
  logic             ch_cout, ch_cmsb;

  assign accept     = in_valid && in_ready;
  assign last       = (cnt == CW'(NCHUNK - 1));
  assign sh         = 32'(cnt) * CHUNK;
  assign a_ch       = CHUNK'(x_r >> sh);
  assign b_ch       = CHUNK'(y_r >> sh);
  assign chunk_zero = (res == '0);
  // on the last chunk, res[CHUNK-1] is the sum MSB and ch_cmsb the carry into bit WIDTH-1
  assign lt = (op_r == OP_SLTU) ? ~ch_cout : (res[CHUNK-1] ^ ch_cmsb ^ ch_cout);

  alu_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_ch),
    .b        (b_ch),
    .cin      (carry_r),
    .op       (op_r),
    .res      (res),
    .cout     (ch_cout),
    .c_msb_in (ch_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_BUSY;
      ST_BUSY: if (last) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = in_valid ? ST_BUSY : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r      <= '0;
      y_r      <= '0;
      f_r      <= '0;
      op_r     <= OP_ADD;
      carry_r  <= 1'b0;
      zero_acc <= 1'b0;
      cnt      <= '0;
      ov_r     <= 1'b0;
      co_r     <= 1'b0;
      zero_r   <= 1'b0;
    end else if (accept) begin
      x_r      <= x;
      y_r      <= is_sub(opcode) ? ~y : y;
      op_r     <= opcode;
      carry_r  <= is_sub(opcode);
      zero_acc <= 1'b1;
      cnt      <= '0;
    end else if (state == ST_BUSY) begin
      f_r      <= (f_r & ~(CMASK << sh)) | (WIDTH'(res) << sh);
      carry_r  <= ch_cout;
      zero_acc <= zero_acc & chunk_zero;
      cnt      <= cnt + CW'(1);
      if (last) begin
        case (op_r)
          OP_ADD, OP_SUB: begin
            ov_r   <= ch_cmsb ^ ch_cout;
            co_r   <= ch_cout;
            zero_r <= zero_acc & chunk_zero;
          end
          OP_SLT, OP_SLTU: begin
            f_r    <= WIDTH'(lt);
            ov_r   <= 1'b0;
            co_r   <= 1'b0;
            zero_r <= ~lt;
          end
          default: begin
            ov_r   <= 1'b0;
            co_r   <= 1'b0;
            zero_r <= zero_acc & chunk_zero;
          end
        endcase
      end
    end
  end

  assign f        = f_r;
  assign overflow = ov_r;
  assign cout     = co_r;
  assign zero     = zero_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and randomised checks of alu_multicycle: vector table, handshake corners, reset abort, chunk-size sweep.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic [2:0]  opcode = OP_ADD;
  logic        in_ready, out_valid, overflow, cout, zero;
  logic [31:0] f;

  // shared stimulus for the CHUNK=1/4/32 instances
  logic        r_valid = 1'b0;
  logic [31:0] r_x = '0, r_y = '0;
  logic [2:0]  r_op = OP_ADD;
  logic [2:0]  r_ir, r_ov, r_vo, r_co, r_z;
  logic [2:0][31:0] r_f;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready), .f(f),
    .overflow(overflow), .cout(cout), .zero(zero));

  alu_multicycle #(.WIDTH(32), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(r_ir[0]), .x(r_x), .y(r_y),
    .opcode(r_op), .out_valid(r_vo[0]), .out_ready(1'b1), .f(r_f[0]),
    .overflow(r_ov[0]), .cout(r_co[0]), .zero(r_z[0]));

  alu_multicycle #(.WIDTH(32), .CHUNK(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(r_ir[1]), .x(r_x), .y(r_y),
    .opcode(r_op), .out_valid(r_vo[1]), .out_ready(1'b1), .f(r_f[1]),
    .overflow(r_ov[1]), .cout(r_co[1]), .zero(r_z[1]));

  alu_multicycle #(.WIDTH(32), .CHUNK(32)) dut_c32 (
    .clk(clk), .rst(rst), .in_valid(r_valid), .in_ready(r_ir[2]), .x(r_x), .y(r_y),
    .opcode(r_op), .out_valid(r_vo[2]), .out_ready(1'b1), .f(r_f[2]),
    .overflow(r_ov[2]), .cout(r_co[2]), .zero(r_z[2]));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ef;
    logic        eov;
    logic        eco;
    logic        ez;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic ov, co;
    ov = 1'b0; co = 1'b0; r = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a | b);
    endcase
    return {r, ov, co, (r == 32'd0)};
  endfunction

  // Issue one op on the main DUT and wait for its result; leaves the result held (out_ready=0).
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit ok);
    int n;
    ok = 1'b1;
    in_valid = 1'b1; x = a; y = b; opcode = op;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) ok = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; x = ~a; y = ~b; opcode = ~op;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bit ok;
    logic [31:0] hf;
    logic hov, hco, hz;
    int bad;
    logic [34:0] exp;
    logic [2:0] got;
    int lat_r [3];
    logic [34:0] res_r [3];
    int exp_lat [3];

    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{OP_SLT,  32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_OR,   32'h12345678, 32'h0F0F0000, 32'h1F3F5678, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_AND,  32'h12345678, 32'h0F0F0000, 32'h02040000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{OP_SLTU, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_ADD,  32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0};

    #1;
    check("reset_state", !out_valid && in_ready && f == 0 && !overflow && !cout && !zero,
          $sformatf("got ov=%b ir=%b f=%h flags=%b%b%b want ov=0 ir=1 f=0 flags=000",
                    out_valid, in_ready, f, overflow, cout, zero));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, ok);
      check($sformatf("vec%0d_latency", i), ok && lat == 4 && out_valid,
            $sformatf("got lat=%0d accepted=%b valid=%b want lat=4", lat, ok, out_valid));
      check($sformatf("vec%0d_result", i),
            f == vecs[i].ef && overflow == vecs[i].eov && cout == vecs[i].eco && zero == vecs[i].ez,
            $sformatf("got f=%h ov=%b co=%b z=%b want f=%h ov=%b co=%b z=%b", f, overflow, cout, zero,
                      vecs[i].ef, vecs[i].eov, vecs[i].eco, vecs[i].ez));
      release_result();
    end

    // Back-pressure: result held for 3 cycles, then back-to-back accept.
    start_op(OP_ADD, 32'h11111111, 32'h22222222, lat, ok);
    hf = f; hov = overflow; hco = cout; hz = zero;
    check("hold_first", ok && out_valid && hf == 32'h33333333,
          $sformatf("got valid=%b f=%h want valid=1 f=33333333", out_valid, hf));
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (!out_valid || in_ready || f != hf || overflow != hov || cout != hco || zero != hz) bad++;
    end
    check("hold_stable", bad == 0, $sformatf("got %0d unstable cycles want 0", bad));
    out_ready = 1'b1; in_valid = 1'b1; x = 32'd10; y = 32'd3; opcode = OP_SUB;
    #1;
    check("b2b_in_ready", in_ready == 1'b1, $sformatf("got in_ready=%b want 1", in_ready));
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; x = '0; y = '0;
    check("b2b_busy", !out_valid && !in_ready,
          $sformatf("got valid=%b in_ready=%b want 0 0", out_valid, in_ready));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_result", lat == 4 && f == 32'd7 && cout && !overflow && !zero,
          $sformatf("got lat=%0d f=%h co=%b ov=%b z=%b want lat=4 f=7 co=1 ov=0 z=0",
                    lat, f, cout, overflow, zero));
    release_result();

    // Reset in the second BUSY cycle aborts the op and clears outputs immediately.
    in_valid = 1'b1; x = 32'h00000001; y = 32'h00000002; opcode = OP_ADD;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", !out_valid && in_ready && f == 0 && !overflow && !cout && !zero,
          $sformatf("got valid=%b ir=%b f=%h flags=%b%b%b want 0 1 0 000",
                    out_valid, in_ready, f, overflow, cout, zero));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad++;
    end
    check("abort_no_result", bad == 0, $sformatf("got %0d bad cycles want 0", bad));

    // Chunk-size sweep against the reference model.
    exp_lat[0] = 32; exp_lat[1] = 8; exp_lat[2] = 1;
    for (int it = 0; it < 30; it++) begin
      r_op = 3'($urandom_range(0, 7));
      case (it % 5)
        0: begin r_x = 32'h80000000; r_y = $urandom; end
        1: begin r_x = $urandom; r_y = r_x; end
        2: begin r_x = 32'h7FFFFFFF; r_y = 32'hFFFFFFFF; end
        default: begin r_x = $urandom; r_y = $urandom; end
      endcase
      exp = model(r_op, r_x, r_y);
      check($sformatf("sweep%0d_ready", it), r_ir == 3'b111,
            $sformatf("got in_ready=%b want 111", r_ir));
      r_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      r_valid = 1'b0;
      got = '0;
      for (int c = 0; c < 40 && got != 3'b111; c++) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (!got[k] && r_vo[k]) begin
            got[k] = 1'b1;
            lat_r[k] = c + 1;
            res_r[k] = {r_f[k], r_ov[k], r_co[k], r_z[k]};
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        check($sformatf("sweep%0d_chunk%0d", it, k),
              got[k] && lat_r[k] == exp_lat[k] && res_r[k] == exp,
              $sformatf("op=%0d x=%h y=%h got done=%b lat=%0d f=%h ovcoz=%b want lat=%0d f=%h ovcoz=%b",
                        r_op, r_x, r_y, got[k], lat_r[k], res_r[k][34:3], res_r[k][2:0],
                        exp_lat[k], exp[34:3], exp[2:0]));
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
